// File: rtl/accel_pkg.sv
// Shared accelerator constants and signed-range helpers used by acc_bound and its sub-blocks.
package accel_pkg;

  localparam int unsigned ACC_A_BW  = 20;
  localparam int unsigned ACC_D_BW  = 8;
  localparam int unsigned ACC_SH_BW = 4;

  // Largest value representable in a w-bit two's-complement word.
  function automatic longint smax(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's-complement word.
  function automatic longint smin(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/acc_bound_if.sv
// Valid/ready stream bus for acc_bound: accumulator beats in, bounded beats and saturation stats out.
interface acc_bound_if
  import accel_pkg::*;
#(
  parameter int unsigned A_BW  = ACC_A_BW,
  parameter int unsigned D_BW  = ACC_D_BW,
  parameter int unsigned SH_BW = ACC_SH_BW
) ();

  logic                    i_valid;
  logic                    o_ready;
  logic signed [A_BW-1:0]  i_acc_data;
  logic        [SH_BW-1:0] i_shift;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [D_BW-1:0]  o_bound_data;
  logic                    o_sat;
  logic                    i_cnt_clr;
  logic        [15:0]      o_sat_cnt;

  modport master (
    output i_valid, i_acc_data, i_shift, i_ready, i_cnt_clr,
    input  o_ready, o_valid, o_bound_data, o_sat, o_sat_cnt
  );

  modport slave (
    input  i_valid, i_acc_data, i_shift, i_ready, i_cnt_clr,
    output o_ready, o_valid, o_bound_data, o_sat, o_sat_cnt
  );

endinterface

// File: rtl/bound_sat.sv
// Combinational clamp of a wide signed value into an OUT_W-bit signed range, flagging any clamp.
module bound_sat
  import accel_pkg::*;
#(
  parameter int unsigned IN_W  = ACC_A_BW + 1,
  parameter int unsigned OUT_W = ACC_D_BW
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] bound_c_o,
  output logic                    sat_c_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(smax(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(smin(OUT_W));

  always_comb begin
    bound_c_o = OUT_W'(din_i);
    sat_c_o   = 1'b0;
    if (din_i > MAX_V) begin
      bound_c_o = OUT_W'(MAX_V);
      sat_c_o   = 1'b1;
    end else if (din_i < MIN_V) begin
      bound_c_o = OUT_W'(MIN_V);
      sat_c_o   = 1'b1;
    end
  end

endmodule

// File: rtl/acc_bound.sv
// Two-stage accumulator bounding pipeline: S1 rounds and arithmetically shifts, S2 saturates to D_BW.
// Define ACC_BOUND_ROUND_EN for round-half-up before the shift; default build floors.
module acc_bound
  import accel_pkg::*;
#(
  parameter int unsigned A_BW  = ACC_A_BW,
  parameter int unsigned D_BW  = ACC_D_BW,
  parameter int unsigned SH_BW = ACC_SH_BW
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  acc_bound_if.slave  bus
);

  localparam int unsigned S1_W  = A_BW + 1;
  localparam int unsigned CNT_W = 16;

  logic                    advance_c;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [S1_W-1:0]  s1_data_q,  s1_data_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [D_BW-1:0]  bound_q, bound_d;
  logic                    sat_q, sat_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [S1_W-1:0]  acc_ext_c;
  logic signed [S1_W-1:0]  rnd_c;
  logic signed [S1_W-1:0]  sum_c;
  logic signed [S1_W-1:0]  shifted_c;
  logic signed [D_BW-1:0]  clamp_c;
  logic                    clamp_sat_c;

  // One extra bit of headroom so the rounding offset cannot overflow.
  always_comb begin
    acc_ext_c = {bus.i_acc_data[A_BW-1], bus.i_acc_data};
    rnd_c     = '0;
`ifdef ACC_BOUND_ROUND_EN
    if (bus.i_shift != '0) begin
      rnd_c = S1_W'(1) << (bus.i_shift - SH_BW'(1));
    end
`endif
    sum_c     = acc_ext_c + rnd_c;
    shifted_c = sum_c >>> bus.i_shift;
  end

  bound_sat #(
    .IN_W  (S1_W),
    .OUT_W (D_BW)
  ) u_bound_sat (
    .din_i     (s1_data_q),
    .bound_c_o (clamp_c),
    .sat_c_o   (clamp_sat_c)
  );

  // Whole pipeline moves together; a stalled output freezes both stages.
  assign advance_c = !out_valid_q || bus.i_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    bound_d     = bound_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;

    if (advance_c) begin
      s1_valid_d  = bus.i_valid;
      out_valid_d = s1_valid_q;
      if (bus.i_valid) begin
        s1_data_d = shifted_c;
      end
      if (s1_valid_q) begin
        bound_d = clamp_c;
        sat_d   = clamp_sat_c;
      end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    if (bus.i_cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && bus.i_ready && sat_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      bound_q     <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      bound_q     <= bound_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_ready      = advance_c;
  assign bus.o_valid      = out_valid_q;
  assign bus.o_bound_data = bound_q;
  assign bus.o_sat        = sat_q;
  assign bus.o_sat_cnt    = cnt_q;

endmodule

// File: tb/tb_acc_bound.sv
// Scoreboard bench for acc_bound: expected beats queued on acceptance, compared on transfer.
module tb_acc_bound;
  import accel_pkg::*;

  localparam int unsigned A_BW  = ACC_A_BW;
  localparam int unsigned D_BW  = ACC_D_BW;
  localparam int unsigned SH_BW = ACC_SH_BW;
  localparam int          N_STIM = 28;

`ifdef ACC_BOUND_ROUND_EN
  localparam bit  ROUND    = 1'b1;
  localparam longint EXP_1004 = 126;
  localparam longint EXP_M3   = -1;
`else
  localparam bit  ROUND    = 1'b0;
  localparam longint EXP_1004 = 125;
  localparam longint EXP_M3   = -2;
`endif

  typedef struct packed {
    logic signed [D_BW-1:0] data;
    logic                   sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic signed [A_BW-1:0]  stim_acc [N_STIM];
  logic        [SH_BW-1:0] stim_sh  [N_STIM];

  acc_bound_if #(.A_BW(A_BW), .D_BW(D_BW), .SH_BW(SH_BW)) bus ();

  acc_bound #(.A_BW(A_BW), .D_BW(D_BW), .SH_BW(SH_BW)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint acc, input int sh);
    longint v;
    exp_t   e;
    v = acc;
    if (ROUND && sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    e.sat = 1'b1;
    if (v > smax(D_BW))      v = smax(D_BW);
    else if (v < smin(D_BW)) v = smin(D_BW);
    else                     e.sat = 1'b0;
    e.data = D_BW'(v);
    return e;
  endfunction

  // Transfer monitor: every output beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_data", bus.o_bound_data, e.data);
        check_eq("sb_sat", bus.o_sat, e.sat);
      end
    end
  end

  task automatic push_exp(input logic signed [A_BW-1:0] acc, input logic [SH_BW-1:0] sh);
    sb.push_back(model(longint'(acc), int'(sh)));
  endtask

  task automatic send(input logic signed [A_BW-1:0] acc, input logic [SH_BW-1:0] sh);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.i_valid    = 1'b1;
    bus.i_acc_data = acc;
    bus.i_shift    = sh;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        push_exp(acc, sh);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("send_accept", ok, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.o_valid;
    end
    check_eq(tag, seen, 1);
  endtask

  // Back-to-back stream from stim[first..first+n-1] with i_ready low for stn cycles from st0.
  task automatic run_stream(input int first, input int n, input int st0, input int stn);
    int idx;
    int cyc;
    bit held_v;
    logic signed [D_BW-1:0] held_d;
    logic held_s;
    idx = 0; cyc = 0; held_v = 1'b0; held_d = '0; held_s = 1'b0;
    while ((idx < n || sb.size() != 0) && cyc < 300) begin
      @(posedge clk); #1;
      bus.i_ready = !(cyc >= st0 && cyc < st0 + stn);
      bus.i_valid = (idx < n);
      if (idx < n) begin
        bus.i_acc_data = stim_acc[first+idx];
        bus.i_shift    = stim_sh[first+idx];
      end
      @(negedge clk);
      if (!bus.i_ready && bus.o_valid) begin
        check_eq("stall_o_ready", bus.o_ready, 0);
        if (held_v) begin
          check_eq("stall_hold_data", bus.o_bound_data, held_d);
          check_eq("stall_hold_sat", bus.o_sat, held_s);
        end
        held_v = 1'b1;
        held_d = bus.o_bound_data;
        held_s = bus.o_sat;
      end else begin
        held_v = 1'b0;
      end
      if (bus.i_valid && bus.o_ready) begin
        push_exp(bus.i_acc_data, bus.i_shift);
        idx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    check_eq("stream_done", (cyc < 300), 1);
    check_eq("stream_drained", sb.size(), 0);
  endtask

  initial begin
    bit stray;

    stim_acc[0] = 20'sd1004;     stim_sh[0] = 4'd3;
    stim_acc[1] = -20'sd3;       stim_sh[1] = 4'd1;
    stim_acc[2] = 20'sd300;      stim_sh[2] = 4'd0;
    stim_acc[3] = -20'sd5000;    stim_sh[3] = 4'd2;
    stim_acc[4] = 20'sd524287;   stim_sh[4] = 4'd15;
    stim_acc[5] = -20'sd524288;  stim_sh[5] = 4'd15;
    stim_acc[6] = -20'sd1;       stim_sh[6] = 4'd15;
    stim_acc[7] = 20'sd127;      stim_sh[7] = 4'd0;
    for (int i = 8; i < N_STIM; i++) begin
      stim_acc[i] = A_BW'($urandom);
      stim_sh[i]  = SH_BW'($urandom_range(0, 15));
    end

    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_acc_data = '0;
    bus.i_shift    = '0;
    bus.i_ready    = 1'b1;
    bus.i_cnt_clr  = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_o_valid", bus.o_valid, 0);
    check_eq("rst_o_data", bus.o_bound_data, 0);
    check_eq("rst_o_sat", bus.o_sat, 0);
    check_eq("rst_sat_cnt", bus.o_sat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", bus.o_ready, 1);

    // Latency: output appears exactly two cycles after the acceptance cycle.
    send(20'sd1004, 4'd3);
    @(negedge clk);
    check_eq("lat_cycle1_valid", bus.o_valid, 0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", bus.o_valid, 1);
    check_eq("dir_1004_data", bus.o_bound_data, EXP_1004);
    check_eq("dir_1004_sat", bus.o_sat, 0);

    send(-20'sd3, 4'd1);
    wait_out("dir_m3_seen");
    check_eq("dir_m3_data", bus.o_bound_data, EXP_M3);

    send(20'sd300, 4'd0);
    wait_out("dir_300_seen");
    check_eq("dir_300_data", bus.o_bound_data, 127);
    check_eq("dir_300_sat", bus.o_sat, 1);

    send(-20'sd5000, 4'd2);
    wait_out("dir_m5000_seen");
    check_eq("dir_m5000_data", bus.o_bound_data, -128);
    check_eq("dir_m5000_sat", bus.o_sat, 1);
    repeat (3) @(negedge clk);
    check_eq("sat_cnt_two", bus.o_sat_cnt, 2);

    run_stream(0, 8, 3, 3);
    run_stream(8, 20, 10, 3);

    // Reset with two beats in flight: both must vanish.
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_acc_data = 20'sd300; bus.i_shift = 4'd0;
    @(posedge clk); #1;
    bus.i_acc_data = -20'sd5000; bus.i_shift = 4'd2;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_o_valid", bus.o_valid, 0);
    check_eq("midrst_o_data", bus.o_bound_data, 0);
    check_eq("midrst_o_sat", bus.o_sat, 0);
    check_eq("midrst_sat_cnt", bus.o_sat_cnt, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.o_valid) stray = 1'b1;
    end
    check_eq("midrst_no_stray", stray, 0);

    // Counter clear racing a saturating transfer.
    send(20'sd300, 4'd0);
    wait_out("clr_pre_seen");
    repeat (2) @(negedge clk);
    check_eq("clr_pre_cnt", bus.o_sat_cnt, 1);
    send(20'sd300, 4'd0);
    wait_out("clr_beat_seen");
    check_eq("clr_beat_sat", bus.o_sat, 1);
    bus.i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.i_cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_priority_cnt", bus.o_sat_cnt, 0);
    check_eq("end_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_bound.md
ACC_BOUND -- requirements
Module: acc_bound

Interface
REQ-001 SHALL have parameter A_BW, default 20, signed accumulator input width.
REQ-002 SHALL have parameter D_BW, default 8, signed bounded output width (the ReLU input width).
REQ-003 SHALL have parameter SH_BW, default 4, shift-amount width; 2^SH_BW-1 < A_BW is required.
REQ-004 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  upstream beat valid.
REQ-007 SHALL have port o_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port i_acc_data  input  A_BW  signed two's-complement accumulator value.
REQ-009 SHALL have port i_shift  input  SH_BW  right-shift amount, sampled with i_acc_data.
REQ-010 SHALL have port o_valid  output  1  output beat valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port o_bound_data  output  D_BW  signed saturated result.
REQ-013 SHALL have port o_sat  output  1  current output beat was clamped.
REQ-014 SHALL have port i_cnt_clr  input  1  synchronous clear of the saturation counter.
REQ-015 SHALL have port o_sat_cnt  output  16  count of clamped beats transferred.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 = round and arithmetic right shift, S2 = clamp to D_BW; latency exactly 2 cycles from accepted input to o_valid when unstalled.
REQ-017 SHALL use a global advance = !o_valid || i_ready; o_ready = advance; with advance low, both stages and all outputs hold.
REQ-018 SHALL accept an input beat on i_valid && o_ready and transfer an output beat on o_valid && i_ready; throughput 1 beat/cycle with i_ready held high.
REQ-019 SHALL propagate S1 valid into S2 on advance, so bubbles move with the data and o_valid never asserts without a captured beat.
REQ-020 SHALL compute S1 in A_BW+1 bits (no overflow on rounding); shift = 0 passes the value unchanged.
REQ-021 SHALL clamp in S2 to [-2^(D_BW-1), 2^(D_BW-1)-1] and set o_sat when the clamp changes the value.
REQ-022 SHALL hold o_bound_data, o_sat and o_valid stable while o_valid && !i_ready.
REQ-023 SHALL increment o_sat_cnt by 1 per transferred beat with o_sat = 1, sticking at 16'hFFFF.
REQ-024 SHALL give i_cnt_clr priority over a same-cycle increment; the counter reads 0 on the next cycle.

Reset
REQ-025 SHALL, on i_rstn low, asynchronously clear S1/S2 valids, o_valid, o_bound_data, o_sat and o_sat_cnt to 0.
REQ-026 SHALL drop any in-flight beats on reset mid-operation, with no output beat produced for them after release.
REQ-027 SHALL drive o_ready = 1 on the first cycle after reset release.

Configuration
REQ-028 SHALL, with ACC_BOUND_ROUND_EN defined, add 2^(shift-1) before the shift when shift > 0 (round half up, toward +inf).
REQ-029 SHALL, without ACC_BOUND_ROUND_EN, shift arithmetically with no offset (floor); ports and latency identical.

Structure
REQ-030 SHALL import a shared package accel_pkg holding the default A_BW/D_BW/SH_BW constants and the signed min/max limit helpers.
REQ-031 SHALL place the S2 clamp in sub-module bound_sat (combinational clamp plus sat flag), instantiated once.

Verification
REQ-032 SHALL cover: acc=1004, shift=3 -> 126 with ROUND_EN, 125 without; o_sat=0; o_valid exactly 2 cycles after acceptance.
REQ-033 SHALL cover: acc=-3, shift=1 -> -1 with ROUND_EN, -2 without.
REQ-034 SHALL cover: acc=300, shift=0 -> 127, o_sat=1; acc=-5000, shift=2 -> -128, o_sat=1; o_sat_cnt ends at 2.
REQ-035 SHALL cover: back-to-back beats with i_ready low for 3 cycles -> output held stable, o_ready=0, no loss or duplication, order preserved.
REQ-036 SHALL cover: i_cnt_clr in the same cycle as a saturating transfer -> o_sat_cnt=0 next cycle.
REQ-037 SHALL cover: i_rstn pulsed low with 2 beats in flight -> outputs 0 immediately, no stale beat after release.
